// File: rtl/bram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Two-port req/gnt arbiter in front of a single-port block RAM.
//               One access in flight at a time; reads return through a
//               registered rdata/rvalid pair after MEM_LAT cycles.
//               Optional feature macro: BRAM_ARB_ROUND_ROBIN_EN
//                 defined     -> round-robin between the two ports
//                 not defined -> fixed priority, port 1 beats port 0
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // Counter must hold MEM_LAT (1..3).
  localparam int c_CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state,    w_state_nx;
  logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nx;
  logic                r_owner,    w_owner_nx;
  logic                r_mem_we,   w_mem_we_nx;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nx;
  logic [DATA_W-1:0]   r_mem_din,  w_mem_din_nx;
  logic                r_m0_gnt,   w_m0_gnt_nx;
  logic                r_m1_gnt,   w_m1_gnt_nx;
  logic                r_m0_rv,    w_m0_rv_nx;
  logic                r_m1_rv,    w_m1_rv_nx;
  logic [DATA_W-1:0]   r_m0_rdata, w_m0_rdata_nx;
  logic [DATA_W-1:0]   r_m1_rdata, w_m1_rdata_nx;

  logic                w_any;
  logic                w_win;

  assign w_any = m0_req | m1_req;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  // Pointer names the port preferred on the next contention.
  logic r_rr, w_rr_nx;
  assign w_win = (m0_req & m1_req) ? r_rr : m1_req;
`else
  // Loader port always wins when it is requesting.
  assign w_win = m1_req;
`endif

  // Next-state and next-output logic; every target defaulted first.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_owner_nx    = r_owner;
    w_mem_we_nx   = 1'b0;
    w_mem_addr_nx = r_mem_addr;
    w_mem_din_nx  = r_mem_din;
    w_m0_gnt_nx   = 1'b0;
    w_m1_gnt_nx   = 1'b0;
    w_m0_rv_nx    = 1'b0;
    w_m1_rv_nx    = 1'b0;
    w_m0_rdata_nx = r_m0_rdata;
    w_m1_rdata_nx = r_m1_rdata;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    w_rr_nx       = r_rr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_owner_nx    = w_win;
          w_mem_we_nx   = w_win ? m1_we    : m0_we;
          w_mem_addr_nx = w_win ? m1_addr  : m0_addr;
          w_mem_din_nx  = w_win ? m1_wdata : m0_wdata;
          w_m0_gnt_nx   = ~w_win;
          w_m1_gnt_nx   = w_win;
          w_state_nx    = S_ACC;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
          w_rr_nx       = ~w_win;
`endif
        end
      end
      S_ACC: begin
        if (r_mem_we) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx   = c_CNT_W'(MEM_LAT);
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_nx = r_cnt - c_CNT_W'(1);
        if (r_cnt == c_CNT_W'(1)) begin
          if (r_owner) begin
            w_m1_rdata_nx = mem_dout;
            w_m1_rv_nx    = 1'b1;
          end else begin
            w_m0_rdata_nx = mem_dout;
            w_m0_rv_nx    = 1'b1;
          end
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_m0_gnt   <= 1'b0;
      r_m1_gnt   <= 1'b0;
      r_m0_rv    <= 1'b0;
      r_m1_rv    <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_owner    <= w_owner_nx;
      r_mem_we   <= w_mem_we_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_mem_din  <= w_mem_din_nx;
      r_m0_gnt   <= w_m0_gnt_nx;
      r_m1_gnt   <= w_m1_gnt_nx;
      r_m0_rv    <= w_m0_rv_nx;
      r_m1_rv    <= w_m1_rv_nx;
      r_m0_rdata <= w_m0_rdata_nx;
      r_m1_rdata <= w_m1_rdata_nx;
    end
  end

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr <= 1'b0;
    end else begin
      r_rr <= w_rr_nx;
    end
  end
`endif

  assign m0_gnt    = r_m0_gnt;
  assign m1_gnt    = r_m1_gnt;
  assign m0_rvalid = r_m0_rv;
  assign m1_rvalid = r_m1_rv;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;

endmodule
`default_nettype wire
